fa_bist: RTL and testbench
==========================

FA_BIST -- requirements
Module: fa_bist

Interface
REQ-001 SETTLE, default 1, number of cycles each vector is driven before the DUT response is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request a test run; sampled on the rising edge of clk.
REQ-005 S  input  1  sum output returned by the full-adder DUT.
REQ-006 c_out  input  1  carry output returned by the full-adder DUT.
REQ-007 A  output  1  registered operand A driven to the DUT.
REQ-008 B  output  1  registered operand B driven to the DUT.
REQ-009 C  output  1  registered carry-in driven to the DUT.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  high from run completion until the next start or rst.
REQ-012 pass  output  1  high when done=1 and err_cnt=0; low at all other times.
REQ-013 err_cnt  output  4  number of mismatching vectors in the current or last run, 0..8.
REQ-014 fail_valid  output  1  high once at least one mismatch has been recorded in the run.
REQ-015 first_fail  output  3  value of {A,B,C} for the first mismatching vector; holds 0 while fail_valid=0.

Function
REQ-016 FSM states shall be IDLE, DRIVE, SAMPLE and DONE; busy shall be 1 exactly in DRIVE and SAMPLE.
REQ-017 In IDLE or DONE, start=1 shall load idx=0, clear err_cnt, fail_valid and first_fail, and go to DRIVE.
REQ-018 In DRIVE and SAMPLE, {A,B,C} shall equal the 3-bit idx, with A as the MSB; in IDLE and DONE, {A,B,C} shall be 000.
REQ-019 DRIVE shall last exactly SETTLE cycles, timed by a wait counter cleared on entry, and then go to SAMPLE.
REQ-020 SAMPLE shall last one cycle; at the end of that cycle the block shall compare S against A^B^C and c_out against majority(A,B,C).
REQ-021 A mismatch on either bit shall increment err_cnt by 1; err_cnt cannot exceed 8.
REQ-022 On the first mismatch of a run, the block shall set fail_valid=1 and capture first_fail=idx; later mismatches shall not update either field.
REQ-023 From SAMPLE: if idx=7, go to DONE; otherwise increment idx and go to DRIVE.
REQ-024 Vector order shall be 000, 001, ..., 111, with each vector applied exactly once per run.
REQ-025 Latency: done shall rise 8*(SETTLE+1) rising edges after the edge that sampled start.
REQ-026 start shall be ignored while busy=1; a start held high shall not restart a run until DONE is reached.
REQ-027 start=1 in DONE shall restart immediately: done and pass fall on the same edge that busy rises.
REQ-028 err_cnt, fail_valid and first_fail shall hold their values in DONE until the next start or rst.
REQ-029 S and c_out shall be sampled only at the end of SAMPLE and shall be ignored in all other states.

Reset
REQ-030 rst=1 on a rising edge shall force IDLE and set A, B, C, busy, done, pass, err_cnt, fail_valid, first_fail, idx and the wait counter to 0.
REQ-031 rst shall take priority over start, including when both are high on the same edge.
REQ-032 rst asserted mid-run shall abort the run with no partial result retained; the first cycle after rst is released shall be IDLE.

Verification
REQ-033 Correct full-adder DUT, SETTLE=1, one-cycle start pulse -> busy for 16 cycles, then done=1, pass=1, err_cnt=0, fail_valid=0.
REQ-034 DUT with c_out stuck at 0, SETTLE=1 -> err_cnt=4 (vectors 011, 101, 110, 111), first_fail=011, fail_valid=1, pass=0.
REQ-035 DUT with S inverted -> err_cnt=8, first_fail=000, pass=0.
REQ-036 rst pulsed on the 5th cycle after start -> next cycle IDLE with all outputs 0; a following start completes with pass=1 after 16 cycles.
REQ-037 start held high for 40 cycles with a correct DUT -> first run completes at cycle 16, restarts on the next edge, and err_cnt is cleared at the restart.
REQ-038 SETTLE=3 with a DUT that has 2 cycles of registered delay -> pass=1, done asserted 32 edges after start.

Source files
------------

// File: rtl/fa_bist_if.sv
// fa_bist_if: start/response/result bundle between the full-adder tester and its surroundings
interface fa_bist_if;
    logic       start;
    logic       S;
    logic       c_out;
    logic       A;
    logic       B;
    logic       C;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_cnt;
    logic       fail_valid;
    logic [2:0] first_fail;

    modport master (
        output start, S, c_out,
        input  A, B, C, busy, done, pass, err_cnt, fail_valid, first_fail
    );

    modport slave (
        input  start, S, c_out,
        output A, B, C, busy, done, pass, err_cnt, fail_valid, first_fail
    );
endinterface

// File: rtl/fa_bist.sv
// fa_bist: exhaustive 8-vector self-test of an external full adder with error count and first-fail capture
module fa_bist #(
    parameter int unsigned SETTLE = 1
) (
    input logic       clk,
    input logic       rst,
    fa_bist_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [3:0] LAST_WAIT = 4'(SETTLE - 1);

    state_t     state_q;
    logic [2:0] idx_q;
    logic [2:0] abc_q;
    logic [3:0] wait_q;
    logic [3:0] err_q;
    logic [3:0] err_d;
    logic       fv_q;
    logic [2:0] ff_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic       mismatch;
    logic       maj;

    always_comb begin
        maj      = (abc_q[2] & abc_q[1]) | (abc_q[2] & abc_q[0]) | (abc_q[1] & abc_q[0]);
        mismatch = (bus.S != ^abc_q) || (bus.c_out != maj);
        err_d    = (mismatch && err_q != 4'd8) ? err_q + 4'd1 : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            abc_q   <= '0;
            wait_q  <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ff_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q <= DRIVE;
                        idx_q   <= '0;
                        abc_q   <= '0;
                        wait_q  <= '0;
                        err_q   <= '0;
                        fv_q    <= 1'b0;
                        ff_q    <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (wait_q == LAST_WAIT) state_q <= SAMPLE;
                    else wait_q <= wait_q + 4'd1;
                end
                SAMPLE: begin
                    err_q <= err_d;
                    if (mismatch && !fv_q) begin
                        fv_q <= 1'b1;
                        ff_q <= idx_q;
                    end
                    if (idx_q == 3'd7) begin
                        state_q <= DONE;
                        abc_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == 4'd0);
                    end else begin
                        state_q <= DRIVE;
                        idx_q   <= idx_q + 3'd1;
                        abc_q   <= idx_q + 3'd1;
                        wait_q  <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.A          = abc_q[2];
    assign bus.B          = abc_q[1];
    assign bus.C          = abc_q[0];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_cnt    = err_q;
    assign bus.fail_valid = fv_q;
    assign bus.first_fail = ff_q;
endmodule

// File: tb/tb_fa_bist.sv
// tb_fa_bist: directed runs against modelled good/faulty adders, results checked through a scoreboard queue
module tb_fa_bist;
    typedef struct packed {
        logic [3:0] err;
        logic       fv;
        logic [2:0] ff;
        logic       pass;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic sel = 1'b0;
    int   mode = 0;
    int   checks = 0;
    int   failures = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    fa_bist_if b1 ();
    fa_bist_if b3 ();

    fa_bist #(.SETTLE(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    fa_bist #(.SETTLE(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

    // u1 sees a combinational adder with selectable faults
    assign b1.start = start & ~sel;
    assign b1.S     = (b1.A ^ b1.B ^ b1.C) ^ (mode == 2);
    assign b1.c_out = (mode == 1) ? 1'b0 : ((b1.A & b1.B) | (b1.A & b1.C) | (b1.B & b1.C));

    // u3 sees a correct adder with two register stages of latency
    logic s1, c1, s2, c2;
    always @(posedge clk) begin
        s1 <= b3.A ^ b3.B ^ b3.C;
        c1 <= (b3.A & b3.B) | (b3.A & b3.C) | (b3.B & b3.C);
        s2 <= s1;
        c2 <= c1;
    end
    assign b3.start = start & sel;
    assign b3.S     = s2;
    assign b3.c_out = c2;

    logic       busy_s, done_s;
    logic [2:0] abc_s;
    res_t       res_s;
    logic [13:0] outs1, outs3;
    assign busy_s = sel ? b3.busy : b1.busy;
    assign done_s = sel ? b3.done : b1.done;
    assign abc_s  = sel ? {b3.A, b3.B, b3.C} : {b1.A, b1.B, b1.C};
    assign res_s  = sel ? {b3.err_cnt, b3.fail_valid, b3.first_fail, b3.pass}
                        : {b1.err_cnt, b1.fail_valid, b1.first_fail, b1.pass};
    assign outs1  = {b1.A, b1.B, b1.C, b1.busy, b1.done, b1.pass, b1.err_cnt, b1.fail_valid, b1.first_fail};
    assign outs3  = {b3.A, b3.B, b3.C, b3.busy, b3.done, b3.pass, b3.err_cnt, b3.fail_valid, b3.first_fail};

    function automatic res_t model(int m);
        res_t r;
        logic [2:0] x;
        logic gs, gc, ds, dc;
        r = '0;
        for (int v = 0; v < 8; v++) begin
            x  = 3'(v);
            gs = ^x;
            gc = (x[2] & x[1]) | (x[2] & x[0]) | (x[1] & x[0]);
            ds = (m == 2) ? ~gs : gs;
            dc = (m == 1) ? 1'b0 : gc;
            if (ds != gs || dc != gc) begin
                r.err = r.err + 4'd1;
                if (!r.fv) begin
                    r.fv = 1'b1;
                    r.ff = x;
                end
            end
        end
        r.pass = (r.err == 4'd0);
        return r;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(int lat, logic s);
        int n;
        res_t r;
        n = 0;
        while (!done_s && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 4) check("abc_mid", 32'(abc_s), s ? 32'd1 : 32'd2);
        end
        check("latency", n, lat);
        check("busy_done", 32'(busy_s), 0);
        if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            r = sb.pop_front();
            check("result", 32'(res_s), 32'(r));
        end
    endtask

    task automatic run(int m, logic s, int lat);
        sel  = s;
        mode = m;
        sb.push_back(model(m));
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_start", 32'(busy_s), 1);
        wait_done(lat, s);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_u1", 32'(outs1), 0);
        check("reset_u3", 32'(outs3), 0);

        run(0, 1'b0, 16);
        check("pass_good", 32'(b1.pass), 1);
        run(1, 1'b0, 16);
        run(2, 1'b0, 16);

        // abort mid-run, then a clean run must still pass
        sel  = 1'b0;
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_mid", 32'(outs1), 0);
        run(0, 1'b0, 16);

        // reset wins over a simultaneous start
        @(negedge clk) begin rst = 1'b1; start = 1'b1; end
        @(posedge clk);
        #1 begin rst = 1'b0; start = 1'b0; end
        check("rst_prio", 32'(outs1), 0);
        @(posedge clk);
        #1 check("rst_prio_idle", 32'(b1.busy), 0);

        // held start: faulty first run, restart clears results, clean second run
        sel  = 1'b0;
        mode = 1;
        sb.push_back(model(1));
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 check("held_busy", 32'(busy_s), 1);
        wait_done(16, 1'b0);
        mode = 0;
        sb.push_back(model(0));
        @(posedge clk);
        #1;
        check("restart_busy", 32'(busy_s), 1);
        check("restart_done", 32'(done_s), 0);
        check("restart_clear", 32'(res_s), 0);
        start = 1'b0;
        wait_done(16, 1'b0);
        @(posedge clk);
        #1 check("done_hold", {28'd0, b1.err_cnt}, 0);

        run(0, 1'b1, 32);
        check("pass_settle3", 32'(b3.pass), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
